// File: rtl/counter_load_arbiter.sv
// Loadable up-counter sequencer: round-robin load arbitration between two
// requesters, enabled counting, terminal-count pulse on wrap, and abort.
module counter_load_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             pclk,
  input  logic             prstn,
  input  logic             preq_a,
  input  logic [WIDTH-1:0] pdat_a,
  input  logic             preq_b,
  input  logic [WIDTH-1:0] pdat_b,
  input  logic             pcnt_en,
  input  logic             pabort,
  output logic             pgnt_a,
  output logic             pgnt_b,
  output logic [WIDTH-1:0] pcnt,
  output logic             ptc,
  output logic             pbusy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             ptr_q;   // 0: A has priority on a tie, 1: B has priority
  logic             ptr_d;
  logic [WIDTH-1:0] cnt_d;
  logic             gnt_a_d;
  logic             gnt_b_d;
  logic             tc_d;

  // Next-state, arbitration and counter update
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = pcnt;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    tc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (preq_a && (!preq_b || !ptr_q)) begin
          gnt_a_d = 1'b1;
          cnt_d   = pdat_a;
          ptr_d   = 1'b1;
          state_d = RUN;
        end else if (preq_b) begin
          gnt_b_d = 1'b1;
          cnt_d   = pdat_b;
          ptr_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort wins over both counting and wrap in the same cycle
        if (pabort) begin
          state_d = IDLE;
        end else if (pcnt_en) begin
          if (&pcnt) begin
            cnt_d   = '0;
            tc_d    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = pcnt + WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      pcnt    <= '0;
      pgnt_a  <= 1'b0;
      pgnt_b  <= 1'b0;
      ptc     <= 1'b0;
      pbusy   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pcnt    <= cnt_d;
      pgnt_a  <= gnt_a_d;
      pgnt_b  <= gnt_b_d;
      ptc     <= tc_d;
      pbusy   <= (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_counter_load_arbiter.sv
// Directed and randomized checks of counter_load_arbiter against a
// cycle-level behavioural model of load/run/wrap/abort rules.
module tb_counter_load_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned MODV  = 1 << WIDTH;

  logic             pclk = 1'b0;
  logic             prstn;
  logic             preq_a, preq_b;
  logic [WIDTH-1:0] pdat_a, pdat_b;
  logic             pcnt_en, pabort;
  logic             pgnt_a, pgnt_b, ptc, pbusy;
  logic [WIDTH-1:0] pcnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_run;
  int unsigned m_cnt;
  bit          m_ptr_b;
  bit          m_ga, m_gb, m_tc;

  counter_load_arbiter #(.WIDTH(WIDTH)) dut (
    .pclk(pclk), .prstn(prstn),
    .preq_a(preq_a), .pdat_a(pdat_a),
    .preq_b(preq_b), .pdat_b(pdat_b),
    .pcnt_en(pcnt_en), .pabort(pabort),
    .pgnt_a(pgnt_a), .pgnt_b(pgnt_b),
    .pcnt(pcnt), .ptc(ptc), .pbusy(pbusy)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_ptr_b = 0; m_ga = 0; m_gb = 0; m_tc = 0;
  endtask

  // One clock of the rules, evaluated from the inputs seen at the edge
  task automatic model_step();
    m_ga = 0; m_gb = 0; m_tc = 0;
    if (!m_run) begin
      if (preq_a && (!preq_b || !m_ptr_b)) begin
        m_ga = 1; m_cnt = pdat_a; m_run = 1; m_ptr_b = 1;
      end else if (preq_b) begin
        m_gb = 1; m_cnt = pdat_b; m_run = 1; m_ptr_b = 0;
      end
    end else if (pabort) begin
      m_run = 0;
    end else if (pcnt_en) begin
      m_cnt = (m_cnt + 1) % MODV;
      if (m_cnt == 0) begin
        m_tc = 1; m_run = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("pcnt",   32'(pcnt),   32'(m_cnt));
    check("pgnt_a", 32'(pgnt_a), 32'(m_ga));
    check("pgnt_b", 32'(pgnt_b), 32'(m_gb));
    check("ptc",    32'(ptc),    32'(m_tc));
    check("pbusy",  32'(pbusy),  32'(m_run));
  endtask

  task automatic step();
    model_step();
    @(posedge pclk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [7:0] gap_exp [4];
    gap_exp[0] = 8'h06; gap_exp[1] = 8'h06; gap_exp[2] = 8'h07; gap_exp[3] = 8'h07;

    prstn = 1'b0; preq_a = 0; preq_b = 0; pdat_a = '0; pdat_b = '0;
    pcnt_en = 0; pabort = 0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    compare_all();
    #3 prstn = 1'b1;
    step();

    // Single load and run to wrap
    preq_a = 1; pdat_a = 8'hFC;
    step();
    check("t1_gnt_a", 32'(pgnt_a), 32'd1);
    check("t1_load",  32'(pcnt),   32'hFC);
    preq_a = 0; pcnt_en = 1;
    repeat (3) step();
    check("t1_ff", 32'(pcnt), 32'hFF);
    step();
    check("t1_wrap_cnt", 32'(pcnt),  32'h00);
    check("t1_wrap_tc",  32'(ptc),   32'd1);
    check("t1_wrap_bsy", 32'(pbusy), 32'd0);
    pcnt_en = 0;
    step();
    check("t1_tc_once", 32'(ptc), 32'd0);

    // Asynchronous reset mid-run at 0x37
    preq_b = 1; pdat_b = 8'h30;
    step();
    preq_b = 0; pcnt_en = 1;
    repeat (7) step();
    check("rst_pre", 32'(pcnt), 32'h37);
    #3 prstn = 1'b0;
    #1;
    model_reset();
    check("rst_cnt",  32'(pcnt),  32'h0);
    check("rst_busy", 32'(pbusy), 32'h0);
    compare_all();
    pcnt_en = 0;
    repeat (2) @(posedge pclk);
    #3 prstn = 1'b1;
    repeat (2) step();
    check("rst_idle", 32'(pbusy), 32'd0);

    // Simultaneous requests and pointer alternation
    preq_a = 1; preq_b = 1; pdat_a = 8'h10; pdat_b = 8'h20;
    step();
    check("sim_gnt_a", 32'(pgnt_a), 32'd1);
    check("sim_cnt_a", 32'(pcnt),   32'h10);
    preq_a = 0; pabort = 1;
    step();
    pabort = 0;
    step();
    check("sim_gnt_b", 32'(pgnt_b), 32'd1);
    check("sim_cnt_b", 32'(pcnt),   32'h20);
    preq_b = 0; pabort = 1;
    step();
    pabort = 0; preq_a = 1; preq_b = 1;
    step();
    check("sim_alt_a", 32'(pgnt_a), 32'd1);
    preq_a = 0; preq_b = 0; pabort = 1;
    step();
    pabort = 0;

    // Enable gaps
    preq_a = 1; pdat_a = 8'h05;
    step();
    preq_a = 0;
    for (int i = 0; i < 4; i++) begin
      pcnt_en = (i % 2 == 0);
      step();
      check("gap_cnt", 32'(pcnt), 32'(gap_exp[i]));
      check("gap_tc",  32'(ptc),  32'd0);
    end
    pcnt_en = 0; pabort = 1;
    step();
    pabort = 0;

    // Abort beats wrap
    preq_a = 1; pdat_a = 8'hFF;
    step();
    preq_a = 0; pcnt_en = 1; pabort = 1;
    step();
    check("abw_cnt",  32'(pcnt),  32'hFF);
    check("abw_tc",   32'(ptc),   32'd0);
    check("abw_busy", 32'(pbusy), 32'd0);
    pcnt_en = 0; pabort = 0;
    step();

    // Request during RUN waits for the wrap edge
    preq_a = 1; pdat_a = 8'hF0;
    step();
    preq_a = 0; pcnt_en = 1; preq_b = 1; pdat_b = 8'h42;
    for (int i = 0; i < 15; i++) begin
      step();
      check("rdr_no_gnt", 32'(pgnt_b), 32'd0);
    end
    step();
    check("rdr_tc",    32'(ptc),    32'd1);
    check("rdr_nogb",  32'(pgnt_b), 32'd0);
    step();
    check("rdr_gnt_b", 32'(pgnt_b), 32'd1);
    check("rdr_cnt",   32'(pcnt),   32'h42);
    preq_b = 0; pcnt_en = 0; pabort = 1;
    step();
    pabort = 0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (preq_a) begin
        if ($urandom_range(15) == 0) preq_a = 0;
      end else if ($urandom_range(3) == 0) begin
        preq_a = 1;
        pdat_a = ($urandom_range(1) == 0) ? WIDTH'($urandom_range(8'hF0, 8'hFF)) : WIDTH'($urandom);
      end
      if (preq_b) begin
        if ($urandom_range(15) == 0) preq_b = 0;
      end else if ($urandom_range(3) == 0) begin
        preq_b = 1;
        pdat_b = ($urandom_range(1) == 0) ? WIDTH'($urandom_range(8'hF0, 8'hFF)) : WIDTH'($urandom);
      end
      pcnt_en = ($urandom_range(3) != 0);
      pabort  = ($urandom_range(15) == 0);
      step();
      if (m_ga) preq_a = 0;
      if (m_gb) preq_b = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
